serial_adder_core: RTL and testbench

- Bit-serial N-bit adder built around the existing one-bit full-adder cell.
- Operands enter on a valid/ready handshake and are added LSB-first, one bit per clock, with the carry held in a register between bits.
- The result is returned on a second valid/ready handshake.
- It is the sequential stage that consumes the full adder's sum/carry outputs and is the next block above that cell in our arithmetic datapath.

---
 rtl/serial_adder_core.sv | 130 +++++++++++++
 tb/tb_serial_adder_core.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_core.sv
// rtl/serial_adder_core.sv - bit-serial N-bit adder around a one-bit full-adder cell
// Operands accepted on in_valid/in_ready, result returned on out_valid/out_ready.

module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_core #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               fa_sum, fa_carry;

    full_adder_cell u_fa (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            sum_sr_q   <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            sum_sr_q   <= sum_sr_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                // in_ready is low on the first edge after reset release, so no accept there
                if (in_valid && in_ready_q) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_sum, sum_sr_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_serial_adder_core.sv
// tb/tb_serial_adder_core.sv - self-checking bench for serial_adder_core
module tb_serial_adder_core;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [7:0] a, b, sum;
    logic       in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2, busy2;
    logic [1:0] a2, b2, sum2;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder_core #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_adder_core #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input int stall, input bit noise);
        logic [8:0] expv;
        int         guard;
        int         lat;
        expv = {1'b0, ta} + {1'b0, tb_v} + {8'd0, tc};
        check("no_valid_before_accept", out_valid, 1'b0);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        check("ready_for_accept", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        check("busy_after_accept", busy, 1'b1);
        check("ready_low_in_shift", in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noise) begin
                in_valid  = ~in_valid;
                a         = 8'h11;
                out_ready = 1'($urandom);
            end
            step();
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("latency", lat, 8);
        check("sum", sum, expv[7:0]);
        check("cout", cout, expv[8]);
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_valid", out_valid, 1'b1);
            check("stall_sum", sum, expv[7:0]);
            check("stall_cout", cout, expv[8]);
            check("stall_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("valid_dropped", out_valid, 1'b0);
        check("ready_after_done", in_ready, 1'b1);
        check("sum_kept", {cout, sum}, expv);
    endtask

    initial begin
        int lat2;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (3) step();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", {cout, sum}, 9'd0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();
        check("release_in_ready", in_ready, 1'b1);

        run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 5, 1'b1);

        // abort mid-shift: accept then three shift edges puts the counter at 3
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("busy_before_abort", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_sum", {cout, sum}, 9'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check("post_abort_ready", in_ready, 1'b1);
        check("post_abort_valid", out_valid, 1'b0);
        run_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1; in_valid2 = 1'b1;
        check("w2_ready", in_ready2, 1'b1);
        step();
        in_valid2 = 1'b0;
        lat2 = 0;
        while (!out_valid2 && lat2 < 20) begin
            step();
            lat2++;
        end
        check("w2_latency", lat2, 2);
        check("w2_sum", sum2, 2'b11);
        check("w2_cout", cout2, 1'b1);
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        check("w2_valid_dropped", out_valid2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
